// File: rtl/int_ctrl_pkg.sv
// Shared types and default parameters for the interrupt controller.
package int_ctrl_pkg;

    localparam int          DEF_N_SRC      = 3;
    localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0000;
    localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0040;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_ctrl_edge_sync.sv
// Two-flop synchroniser for one asynchronous request line, plus a rising-edge pulse.
module edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic s1, s2, s3;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge-latched pending bits, software mask, fixed priority, ack/eret handshake.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC      = DEF_N_SRC,
    parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
    parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
    localparam int         ID_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_in,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_din,
    input  logic             int_ack,
    input  logic             int_eret,
    output logic [N_SRC-1:0] mask,
    output logic [N_SRC-1:0] pending,
    output logic             irq,
    output logic [ID_W-1:0]  irq_id,
    output logic [31:0]      irq_vec,
    output logic             busy
);

    state_t            state, state_n;
    logic [N_SRC-1:0]  src_edge;
    logic [N_SRC-1:0]  cand;
    logic [N_SRC-1:0]  clr_mask;
    logic [N_SRC-1:0]  pending_n;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   irq_id_n;
    logic              take;

    for (genvar i = 0; i < N_SRC; i++) begin : g_sync
        edge_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .din   (src_in[i]),
            .pulse (src_edge[i])
        );
    end

    assign cand = pending & ~mask;

    // Ascending scan: the last set bit seen is the highest index, i.e. highest priority.
    always_comb begin
        winner = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cand[i]) winner = ID_W'(i);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        irq_id_n = irq_id;
        take     = 1'b0;
        unique case (state)
            IDLE: begin
                if (|cand) begin
                    state_n  = REQ;
                    irq_id_n = winner;
                end
            end
            REQ: begin
                // The core has already committed once it acks, so ack beats a vanished candidate.
                if (int_ack) begin
                    state_n = SERVICE;
                    take    = 1'b1;
                end else if (|cand) begin
                    irq_id_n = winner;
                end else begin
                    state_n = IDLE;
                end
            end
            SERVICE: begin
                if (int_eret) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // A fresh edge is OR-ed in after the clear so it survives a same-cycle ack.
    assign clr_mask  = take ? ({{(N_SRC-1){1'b0}}, 1'b1} << irq_id) : '0;
    assign pending_n = (pending & ~clr_mask) | src_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            mask    <= '0;
            pending <= '0;
            irq     <= 1'b0;
            irq_id  <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= pending_n;
            irq     <= (state_n == REQ);
            irq_id  <= irq_id_n;
            busy    <= (state_n == SERVICE);
            if (mask_we) mask <= mask_din;
        end
    end

    assign irq_vec = VEC_BASE + 32'(irq_id) * VEC_STRIDE;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with hand-computed expectations at each step.
module tb_int_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] src_in;
    logic       mask_we;
    logic [2:0] mask_din;
    logic       int_ack;
    logic       int_eret;
    logic [2:0] mask;
    logic [2:0] pending;
    logic       irq;
    logic [1:0] irq_id;
    logic [31:0] irq_vec;
    logic       busy;

    int n_pass  = 0;
    int n_total = 0;

    int_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .src_in   (src_in),
        .mask_we  (mask_we),
        .mask_din (mask_din),
        .int_ack  (int_ack),
        .int_eret (int_eret),
        .mask     (mask),
        .pending  (pending),
        .irq      (irq),
        .irq_id   (irq_id),
        .irq_vec  (irq_vec),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_state(input string tag, input logic [2:0] e_pend, input logic e_irq,
                               input logic [1:0] e_id, input logic e_busy);
        check({tag, ".pending"}, 32'(pending), 32'(e_pend));
        check({tag, ".irq"},     32'(irq),     32'(e_irq));
        check({tag, ".irq_id"},  32'(irq_id),  32'(e_id));
        check({tag, ".busy"},    32'(busy),    32'(e_busy));
    endtask

    initial begin
        rst = 1'b1; src_in = '0; mask_we = 1'b0; mask_din = '0; int_ack = 1'b0; int_eret = 1'b0;
        tick(2);
        rst = 1'b0;
        check("rst.mask", 32'(mask), 32'h0);
        check_state("rst", 3'b000, 1'b0, 2'd0, 1'b0);
        check("rst.vec", irq_vec, 32'h0);

        // Source 0 pulse: pending after k+2, irq after k+3.
        src_in[0] = 1'b1;
        tick(2);
        check("s0.k1.pending", 32'(pending), 32'h0);
        tick();
        src_in[0] = 1'b0;
        check_state("s0.k2", 3'b001, 1'b0, 2'd0, 1'b0);
        tick();
        check_state("s0.k3", 3'b001, 1'b1, 2'd0, 1'b0);
        check("s0.vec", irq_vec, 32'h0);

        // Higher-priority source 2 re-targets the outstanding request.
        src_in[2] = 1'b1;
        tick(3);
        src_in[2] = 1'b0;
        check_state("s2.k2", 3'b101, 1'b1, 2'd0, 1'b0);
        tick();
        check_state("s2.k3", 3'b101, 1'b1, 2'd2, 1'b0);
        check("s2.vec", irq_vec, 32'h80);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_state("ack2", 3'b001, 1'b0, 2'd2, 1'b1);

        // Edge on source 1 during service stays pending, no irq until eret.
        src_in[1] = 1'b1;
        tick(3);
        src_in[1] = 1'b0;
        tick(2);
        check_state("svc2.s1", 3'b011, 1'b0, 2'd2, 1'b1);
        int_eret = 1'b1; tick(); int_eret = 1'b0;
        check_state("eret2", 3'b011, 1'b0, 2'd2, 1'b0);
        tick();
        check_state("eret2.j1", 3'b011, 1'b1, 2'd1, 1'b0);
        check("s1.vec", irq_vec, 32'h40);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_state("ack1", 3'b001, 1'b0, 2'd1, 1'b1);
        int_eret = 1'b1; tick(); int_eret = 1'b0;
        tick();
        check_state("req0", 3'b001, 1'b1, 2'd0, 1'b0);

        // New edge on source 0 in the same cycle as its ack: set wins.
        src_in[0] = 1'b1;
        tick(2);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        src_in[0] = 1'b0;
        check_state("ack0.race", 3'b001, 1'b0, 2'd0, 1'b1);
        int_eret = 1'b1; tick(); int_eret = 1'b0;
        tick();
        check_state("race.rereq", 3'b001, 1'b1, 2'd0, 1'b0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_state("ack0", 3'b000, 1'b0, 2'd0, 1'b1);
        int_eret = 1'b1; tick(); int_eret = 1'b0;
        tick(2);
        check_state("idle", 3'b000, 1'b0, 2'd0, 1'b0);

        // Masked source latches but does not request until unmasked.
        mask_din = 3'b010; mask_we = 1'b1; tick(); mask_we = 1'b0;
        check("mask.wr", 32'(mask), 32'h2);
        src_in[1] = 1'b1;
        tick(3);
        src_in[1] = 1'b0;
        tick(3);
        check_state("masked", 3'b010, 1'b0, 2'd0, 1'b0);
        mask_din = 3'b000; mask_we = 1'b1; tick(); mask_we = 1'b0;
        check("unmask.mask", 32'(mask), 32'h0);
        check("unmask.w0.irq", 32'(irq), 32'h0);
        tick();
        check_state("unmask.w1", 3'b010, 1'b1, 2'd1, 1'b0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_state("ack1b", 3'b000, 1'b0, 2'd1, 1'b1);

        // Reset in SERVICE with two pending sources discards everything.
        mask_din = 3'b100; mask_we = 1'b1; tick(); mask_we = 1'b0;
        src_in[1:0] = 2'b11;
        tick(3);
        src_in[1:0] = 2'b00;
        tick(2);
        check_state("pre.rst", 3'b011, 1'b0, 2'd1, 1'b1);
        check("pre.rst.mask", 32'(mask), 32'h4);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2.mask", 32'(mask), 32'h0);
        check_state("rst2", 3'b000, 1'b0, 2'd0, 1'b0);
        check("rst2.vec", irq_vec, 32'h0);
        int_eret = 1'b1; tick(); int_eret = 1'b0;
        check_state("spur.eret", 3'b000, 1'b0, 2'd0, 1'b0);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        tick();
        check_state("spur.ack", 3'b000, 1'b0, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller sitting between peripherals and the CPU core's interrupt inputs; it is the request-side counterpart of the core's CP0 interrupt logic. It synchronises raw peripheral request lines and latches rising edges as pending bits. It applies a software mask, selects the highest-priority request and drives a level `irq` with source id and entry vector. It retires requests on the core's take-interrupt acknowledge and re-arms on exception return (eret).

## Interface
- `N_SRC`, 3, number of interrupt sources; bit `N_SRC-1` is highest priority.
- `VEC_BASE`, 32'h0000_0000, entry address for source 0.
- `VEC_STRIDE`, 32'h0000_0040, byte distance between consecutive source entries.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `src_in`  in  N_SRC  raw peripheral request lines, asynchronous to `clk`.
- `mask_we`  in  1  write strobe for mask register.
- `mask_din`  in  N_SRC  new mask value; 1 = source blocked.
- `int_ack`  in  1  one-cycle pulse: core has taken the presented interrupt (EPC saved, PC redirected).
- `int_eret`  in  1  one-cycle pulse: core executed exception return.
- `mask`  out  N_SRC  current mask register.
- `pending`  out  N_SRC  latched, not-yet-acknowledged edges.
- `irq`  out  1  registered interrupt request to core.
- `irq_id`  out  clog2(N_SRC)  id of request presented (REQ) or being serviced (SERVICE).
- `irq_vec`  out  32  `VEC_BASE + irq_id*VEC_STRIDE`, modulo 2^32.
- `busy`  out  1  high in SERVICE.

## Operation
- Per source: 2-flop synchroniser, then rising-edge detector against a third flop; a detected edge sets `pending[i]`.
- Candidate set = `pending & ~mask`; winner = highest set index.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: candidate set non-empty -> REQ, `irq_id` <= winner.
  - REQ: `irq`=1. Each cycle `irq_id` <= current winner (higher-priority arrival or mask change re-targets). Candidate set empty -> IDLE. `int_ack` -> SERVICE, clear `pending[irq_id]`, hold `irq_id`.
  - SERVICE: `irq`=0, `busy`=1, `irq_id` frozen; new edges still set pending. `int_eret` -> IDLE.
- No nesting: at most one source in service.
- `int_ack` outside REQ and `int_eret` outside SERVICE are ignored.
- Edge on source `k` in the same cycle its ack clears `pending[k]`: set wins, bit stays 1.
- `mask_we` updates `mask` next edge; masking never clears pending bits.
- Reset: `mask`, `pending`, synchroniser/edge flops, `irq`, `irq_id`, `busy` all 0; `irq_vec` = `VEC_BASE`; state IDLE. Reset mid-service discards in-service and pending state.

## Timing
- `src_in` rising, first sampled at edge k: `pending` set after edge k+2; state REQ and `irq`=1 after edge k+3 (no request already outstanding).
- `int_ack` sampled at edge j: `irq`=0, `busy`=1 after edge j; pending bit clear after edge j.
- `int_eret` at edge j: IDLE after j; a remaining candidate raises `irq` after edge j+1.
- `src_in` held high generates one edge only; re-request requires a low of at least 2 cycles.
- `irq_vec` combinational from `irq_id`, stable whenever `irq`=1.

## Structure
- Package `int_ctrl_pkg`: state enum (IDLE, REQ, SERVICE), default `N_SRC`, `VEC_BASE`, `VEC_STRIDE`.
- Sub-module `edge_sync`: 2-flop synchroniser plus rising-edge pulse, instantiated once per source.
- Priority encoder and vector arithmetic inline.

## Test plan
- Reset, then pulse `src_in[0]` high 3 cycles -> `pending`=3'b001 after k+2, `irq`=1, `irq_id`=0, `irq_vec`=0x0 after k+3.
- In REQ on source 0, raise `src_in[2]` -> `irq_id` becomes 2, `irq_vec`=0x80 before ack; `int_ack` -> `pending`=3'b001, `busy`=1.
- `mask_din`=3'b010, raise `src_in[1]` -> `pending`=3'b010, `irq` stays 0; write mask 0 -> `irq`=1, `irq_id`=1 two edges after write.
- In SERVICE on source 2, edge on `src_in[1]` -> `irq`=0 until `int_eret`, then `irq`=1, `irq_id`=1 one cycle later.
- Edge on `src_in[0]` arriving in `int_ack` cycle for source 0 -> `pending[0]` remains 1; after eret, `irq` reasserts with `irq_id`=0.
- Assert `rst` during SERVICE with pending 3'b011 -> all outputs 0, state IDLE; spurious `int_eret`/`int_ack` then leave outputs unchanged.
